// File: rtl/ft600_bus_responder.sv
// FT600 245-sync-FIFO responder: answers the FPGA bus master from two FIFOs.
// Define FT600_RESP_LOOPBACK_EN to echo master writes back as master reads.
module ft600_bus_responder #(
  parameter int FIFO_AW = 4
) (
  input  logic               ftdi_clk,
  input  logic               rst_n,
  output logic               ftdi_rxf_n,
  output logic               ftdi_txe_n,
  input  logic               ftdi_oe_n,
  input  logic               ftdi_rd_n,
  input  logic               ftdi_wr_n,
  inout  wire  [15:0]        ftdi_data,
  inout  wire  [1:0]         ftdi_be,
  input  logic [15:0]        host_in_data,
  input  logic [1:0]         host_in_be,
  input  logic               host_in_valid,
  output logic               host_in_ready,
  output logic [15:0]        host_out_data,
  output logic [1:0]         host_out_be,
  output logic               host_out_valid,
  input  logic               host_out_ready,
  output logic [FIFO_AW:0]   rx_level,
  output logic [FIFO_AW:0]   tx_level,
  output logic               err_underrun,
  output logic               err_overflow,
  output logic               err_contention,
  input  logic               err_clear
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE  = (FIFO_AW+1)'(1);

  logic [17:0] rx_mem [DEPTH];
  logic [17:0] tx_mem [DEPTH];

  logic [FIFO_AW-1:0] rx_rd_q, rx_wr_q;
  logic [FIFO_AW-1:0] tx_rd_q, tx_wr_q;
  logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d;
  logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d;
  logic               drive_en_q;
  logic               alive_q;
  logic               rxf_n_q, txe_n_q;
  logic               err_u_q, err_o_q, err_c_q;

  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rd_req, wr_req;
  logic        rx_pop, rx_push, tx_pop, tx_push;
  logic        ev_under, ev_over, ev_cont;
  logic [17:0] rx_head, tx_head, rx_wdata;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL);

  assign rx_head = rx_empty ? 18'h0 : rx_mem[rx_rd_q];
  assign tx_head = tx_empty ? 18'h0 : tx_mem[tx_rd_q];

  assign rd_req   = ~ftdi_rd_n & drive_en_q;
  assign rx_pop   = rd_req & ~rx_empty;
  assign ev_under = rd_req & rx_empty;

  assign wr_req  = ~ftdi_wr_n;
  assign ev_cont = wr_req & (~ftdi_oe_n | drive_en_q);
  assign ev_over = wr_req & ~ev_cont & tx_full;
  assign tx_push = wr_req & ~ev_cont & ~tx_full;

`ifdef FT600_RESP_LOOPBACK_EN
  logic loop_mv;
  // RX space is judged after this cycle's master pop
  assign loop_mv =
    ~tx_empty & ((rx_cnt_q - (rx_pop ? ONE : '0)) != FULL);
  assign rx_push        = loop_mv;
  assign rx_wdata       = tx_head;
  assign tx_pop         = loop_mv;
  assign host_in_ready  = 1'b0;
  assign host_out_valid = 1'b0;
`else
  assign host_in_ready  = alive_q & ~rx_full;
  assign rx_push        = host_in_valid & host_in_ready;
  assign rx_wdata       = {host_in_be, host_in_data};
  assign host_out_valid = ~tx_empty;
  assign tx_pop         = host_out_valid & host_out_ready;
`endif

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push) rx_cnt_d = rx_cnt_d + ONE;
    if (rx_pop)  rx_cnt_d = rx_cnt_d - ONE;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) tx_cnt_d = tx_cnt_d + ONE;
    if (tx_pop)  tx_cnt_d = tx_cnt_d - ONE;
  end

  always_ff @(posedge ftdi_clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_wdata;
    if (tx_push) tx_mem[tx_wr_q] <= {ftdi_be, ftdi_data};
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rd_q    <= '0;
      rx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_wr_q    <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      drive_en_q <= 1'b0;
      alive_q    <= 1'b0;
      rxf_n_q    <= 1'b1;
      txe_n_q    <= 1'b1;
      err_u_q    <= 1'b0;
      err_o_q    <= 1'b0;
      err_c_q    <= 1'b0;
    end else begin
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      drive_en_q <= ~ftdi_oe_n;
      alive_q    <= 1'b1;
      rxf_n_q    <= (rx_cnt_d == '0);
      txe_n_q    <= (tx_cnt_d == FULL);
      err_u_q    <= ev_under | (err_u_q & ~err_clear);
      err_o_q    <= ev_over  | (err_o_q & ~err_clear);
      err_c_q    <= ev_cont  | (err_c_q & ~err_clear);
    end
  end

  assign ftdi_data = drive_en_q ? rx_head[15:0]  : 16'hzzzz;
  assign ftdi_be   = drive_en_q ? rx_head[17:16] : 2'bzz;

  assign ftdi_rxf_n     = rxf_n_q;
  assign ftdi_txe_n     = txe_n_q;
  assign host_out_data  = tx_head[15:0];
  assign host_out_be    = tx_head[17:16];
  assign rx_level       = rx_cnt_q;
  assign tx_level       = tx_cnt_q;
  assign err_underrun   = err_u_q;
  assign err_overflow   = err_o_q;
  assign err_contention = err_c_q;

endmodule

// File: tb/tb_ft600_bus_responder.sv
// Bench for ft600_bus_responder: queue-based model checked every negedge,
// plus directed bus/host sequences with literal expectations.
module tb_ft600_bus_responder;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        oe_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        tb_drive = 1'b0;
  logic [15:0] tb_wdata = '0;
  logic [1:0]  tb_wbe = '0;
  wire  [15:0] ftdi_data;
  wire  [1:0]  ftdi_be;
  logic        rxf_n, txe_n;
  logic [15:0] hi_data = '0;
  logic [1:0]  hi_be = '0;
  logic        hi_valid = 1'b0, hi_ready;
  logic [15:0] ho_data;
  logic [1:0]  ho_be;
  logic        ho_valid, ho_ready = 1'b0;
  logic [AW:0] rx_level, tx_level;
  logic        e_u, e_o, e_c;
  logic        err_clear = 1'b0;

  assign ftdi_data = tb_drive ? tb_wdata : 16'hzzzz;
  assign ftdi_be   = tb_drive ? tb_wbe   : 2'bzz;

  ft600_bus_responder #(.FIFO_AW(AW)) dut (
    .ftdi_clk(clk), .rst_n(rst_n),
    .ftdi_rxf_n(rxf_n), .ftdi_txe_n(txe_n),
    .ftdi_oe_n(oe_n), .ftdi_rd_n(rd_n), .ftdi_wr_n(wr_n),
    .ftdi_data(ftdi_data), .ftdi_be(ftdi_be),
    .host_in_data(hi_data), .host_in_be(hi_be),
    .host_in_valid(hi_valid), .host_in_ready(hi_ready),
    .host_out_data(ho_data), .host_out_be(ho_be),
    .host_out_valid(ho_valid), .host_out_ready(ho_ready),
    .rx_level(rx_level), .tx_level(tx_level),
    .err_underrun(e_u), .err_overflow(e_o),
    .err_contention(e_c), .err_clear(err_clear)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model state: plain word queues and flags
  logic [17:0] m_rx[$];
  logic [17:0] m_tx[$];
  bit m_de, m_alive, m_rxf_n = 1'b1, m_txe_n = 1'b1;
  bit m_eu, m_eo, m_ec;

  always @(posedge clk or negedge rst_n) begin : model
    int rs, ts;
    bit rd, pop, und, wr, con, ovf, tpush, push, tpop;
    logic [17:0] w;
    if (!rst_n) begin
      m_rx.delete(); m_tx.delete();
      m_de = 0; m_alive = 0; m_rxf_n = 1; m_txe_n = 1;
      m_eu = 0; m_eo = 0; m_ec = 0;
    end else begin
      rs = m_rx.size(); ts = m_tx.size();
      rd  = !rd_n && m_de;
      pop = rd && rs > 0;
      und = rd && rs == 0;
      wr  = !wr_n;
      con = wr && (!oe_n || m_de);
      ovf = wr && !con && ts == DEPTH;
      tpush = wr && !con && ts < DEPTH;
`ifdef FT600_RESP_LOOPBACK_EN
      push = ts > 0 && (rs - int'(pop)) < DEPTH;
      tpop = push;
      w = (ts > 0) ? m_tx[0] : 18'h0;
`else
      push = hi_valid && m_alive && rs < DEPTH;
      tpop = ts > 0 && ho_ready;
      w = {hi_be, hi_data};
`endif
      if (pop)   void'(m_rx.pop_front());
      if (push)  m_rx.push_back(w);
      if (tpop)  void'(m_tx.pop_front());
      if (tpush) m_tx.push_back({tb_wbe, tb_wdata});
      m_rxf_n = (m_rx.size() == 0);
      m_txe_n = (m_tx.size() == DEPTH);
      m_eu = und || (m_eu && !err_clear);
      m_eo = ovf || (m_eo && !err_clear);
      m_ec = con || (m_ec && !err_clear);
      m_de = !oe_n;
      m_alive = 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [17:0] head;
    chk("rx_level", rx_level, m_rx.size());
    chk("tx_level", tx_level, m_tx.size());
    chk("rxf_n", rxf_n, m_rxf_n);
    chk("txe_n", txe_n, m_txe_n);
    chk("err_underrun", e_u, m_eu);
    chk("err_overflow", e_o, m_eo);
    chk("err_contention", e_c, m_ec);
`ifdef FT600_RESP_LOOPBACK_EN
    chk("host_in_ready", hi_ready, 0);
    chk("host_out_valid", ho_valid, 0);
`else
    chk("host_in_ready", hi_ready, m_alive && m_rx.size() < DEPTH);
    chk("host_out_valid", ho_valid, m_tx.size() != 0);
    head = (m_tx.size() != 0) ? m_tx[0] : 18'h0;
    chk("host_out_data", ho_data, head[15:0]);
    chk("host_out_be", ho_be, head[17:16]);
`endif
    if (m_de) begin
      head = (m_rx.size() != 0) ? m_rx[0] : 18'h0;
      chk("bus_data", ftdi_data, head[15:0]);
      chk("bus_be", ftdi_be, head[17:16]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst rxf_n", rxf_n, 1);
    chk("rst txe_n", txe_n, 1);
    chk("rst rx_level", rx_level, 0);
    chk("rst host_in_ready", hi_ready, 0);
    rst_n = 1'b1;
    chk("post-release txe_n", txe_n, 1);
    chk("post-release ready", hi_ready, 0);
    step();
    chk("first edge txe_n", txe_n, 0);
`ifndef FT600_RESP_LOOPBACK_EN
    chk("first edge ready", hi_ready, 1);
    for (int i = 0; i < 3; i++) begin
      hi_valid = 1'b1; hi_data = 16'hA001 + 16'(i); hi_be = 2'b11;
      step();
    end
    hi_valid = 1'b0;
    chk("push3 rx_level", rx_level, 3);
    chk("push3 rxf_n", rxf_n, 0);
    oe_n = 1'b0; step();
    chk("read0", ftdi_data, 16'hA001);
    rd_n = 1'b0; step();
    chk("read1", ftdi_data, 16'hA002);
    step();
    chk("read2", ftdi_data, 16'hA003);
    chk("read2 be", ftdi_be, 2'b11);
    step(); rd_n = 1'b1;
    chk("drained rxf_n", rxf_n, 1);
    chk("empty bus", ftdi_data, 16'h0000);
    oe_n = 1'b1; step();
    for (int i = 0; i < 17; i++) begin
      wr_n = 1'b0; tb_drive = 1'b1;
      tb_wdata = 16'hB000 + 16'(i); tb_wbe = 2'(i);
      step();
    end
    wr_n = 1'b1; tb_drive = 1'b0;
    chk("ovf tx_level", tx_level, 16);
    chk("ovf txe_n", txe_n, 1);
    chk("ovf flag", e_o, 1);
    chk("tx head", ho_data, 16'hB000);
    chk("tx head be", ho_be, 2'b00);
    ho_ready = 1'b1; step();
    chk("tx pop1", ho_data, 16'hB001);
    step(); ho_ready = 1'b0;
    chk("tx pop2 level", tx_level, 14);
    oe_n = 1'b0; wr_n = 1'b0; step();
    wr_n = 1'b1; oe_n = 1'b1;
    chk("contention flag", e_c, 1);
    chk("contention level", tx_level, 14);
    step();
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk("clear contention", e_c, 0);
    chk("clear overflow", e_o, 0);
    oe_n = 1'b0; step();
    rd_n = 1'b0; step(); rd_n = 1'b1;
    chk("underrun flag", e_u, 1);
    rd_n = 1'b0; err_clear = 1'b1; step();
    rd_n = 1'b1; err_clear = 1'b0; oe_n = 1'b1;
    chk("event beats clear", e_u, 1);
    step();
    ho_ready = 1'b1;
    repeat (14) step();
    ho_ready = 1'b0;
    chk("tx drained", ho_valid, 0);
    for (int i = 0; i < 16; i++) begin
      hi_valid = 1'b1; hi_data = 16'hC000 + 16'(i); hi_be = 2'b10;
      step();
    end
    hi_valid = 1'b0;
    chk("rx full level", rx_level, 16);
    chk("rx full ready", hi_ready, 0);
    oe_n = 1'b0; step();
    rd_n = 1'b0; hi_valid = 1'b1; hi_data = 16'hDEAD; step();
    rd_n = 1'b1; hi_valid = 1'b0;
    chk("full pop level", rx_level, 15);
    chk("full pop ready", hi_ready, 1);
    chk("full pop head", ftdi_data, 16'hC001);
    rd_n = 1'b0; step(); rd_n = 1'b1;
    rst_n = 1'b0; #1;
    chk("async rst level", rx_level, 0);
    chk("async rst rxf_n", rxf_n, 1);
    oe_n = 1'b1; step();
    rst_n = 1'b1; step(); step();
`else
    wr_n = 1'b0; tb_drive = 1'b1;
    tb_wdata = 16'h1234; tb_wbe = 2'b01; step();
    tb_wdata = 16'h5678; tb_wbe = 2'b10; step();
    wr_n = 1'b1; tb_drive = 1'b0;
    chk("loop rxf_n", rxf_n, 0);
    step();
    chk("loop rx_level", rx_level, 2);
    oe_n = 1'b0; step();
    chk("loop read0", ftdi_data, 16'h1234);
    chk("loop be0", ftdi_be, 2'b01);
    rd_n = 1'b0; step();
    chk("loop read1", ftdi_data, 16'h5678);
    chk("loop be1", ftdi_be, 2'b10);
    step(); rd_n = 1'b1;
    chk("loop drained", rxf_n, 1);
    oe_n = 1'b1; step(); step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
